hazard_stall_ctrl: RTL



---
 rtl/mips_pkg.sv | 14 +
 rtl/load_use_detect.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard control slice.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO       = 0;
  localparam int unsigned LU_CNT_W       = 4;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  mem_read_ex_i,
  input  logic [REG_ADDR_W-1:0] rt_ex_i,
  input  logic [REG_ADDR_W-1:0] rs_id_i,
  input  logic [REG_ADDR_W-1:0] rt_id_i,
  input  logic                  uses_rt_id_i,
  output logic                  hazard_o
);

  logic dest_valid;
  logic rs_match;
  logic rt_match;

  always_comb begin
    dest_valid = mem_read_ex_i && (rt_ex_i != REG_ADDR_W'(REG_ZERO));
    rs_match   = (rt_ex_i == rs_id_i);
    rt_match   = uses_rt_id_i && (rt_ex_i == rt_id_i);
    hazard_o   = dest_valid && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, dmem-busy freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_count outputs.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned REG_ADDR_W      = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_memRead_id_ex,
  input  logic [REG_ADDR_W-1:0] rt_id_ex,
  input  logic [REG_ADDR_W-1:0] rs_if_id,
  input  logic [REG_ADDR_W-1:0] rt_if_id,
  input  logic                  uses_rt_if_id,
  input  logic                  branch_taken_mem,
  input  logic                  dmem_busy,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_flush,
  output logic                  pipe_hold
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LOAD_USE_CYCLES - 1);
  localparam logic [LU_CNT_W-1:0] LU_ONE    = LU_CNT_W'(1);

  hz_state_t             state_q, state_d;
  hz_state_t             saved_q, saved_d;
  hz_state_t             eff_state;
  logic [LU_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  hazard;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .mem_read_ex_i (ctrl_memRead_id_ex),
    .rt_ex_i       (rt_id_ex),
    .rs_id_i       (rs_if_id),
    .rt_id_i       (rt_if_id),
    .uses_rt_id_i  (uses_rt_if_id),
    .hazard_o      (hazard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle leaving MEM_WAIT behaves exactly as the saved state would,
  // so a frozen stall resumes with its remaining count in that same cycle.
  always_comb begin
    state_d        = state_q;
    saved_d        = saved_q;
    cnt_d          = cnt_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_flush   = 1'b0;
    pipe_hold      = 1'b0;
    eff_state      = (state_q == MEM_WAIT) ? saved_q : state_q;

    if (dmem_busy) begin
      pipe_hold      = 1'b1;
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if (state_q != MEM_WAIT) begin
        saved_d = state_q;
      end
      state_d = MEM_WAIT;
    end else begin
      saved_d = RUN;
      if (branch_taken_mem) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = RUN;
        cnt_d        = '0;
      end else if (eff_state == LU_STALL) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
        if (cnt_q <= LU_ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          state_d = LU_STALL;
          cnt_d   = cnt_q - LU_ONE;
        end
      end else if (hazard) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          state_d = LU_STALL;
          cnt_d   = LU_RELOAD;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end

    if (!reset) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      ex_mem_flush   = 1'b1;
      pipe_hold      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        stall_inc;
  logic        flush_inc;

  // A bubble without ex_mem_flush is a load-use bubble; a flush with PC
  // enabled is a branch (reset flushes with PC disabled).
  always_comb begin
    stall_inc = (id_ex_bubble && !ex_mem_flush) || pipe_hold;
    flush_inc = ex_mem_flush && pc_write_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush_inc && (flush_q != '1)) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule
